rmst_arbiter: RTL

Shares the single AXI read-master channel between `NUM_REQ` input-side buffers (input feature buffer, weight buffer, ...), each of which raises one-cycle `rmst_req` pulses with its own `addr_offset`/`xfer_size`. It does the following:
- latches pending requests;
- grants them round-robin, issuing one burst at a time to the read master;
- steers the returned data stream to the granted buffer's FIFO push port;
- returns a per-requester `rmst_done` only when the burst has fully landed.

It sits between the buffers and the read-master/kernel top.

---
 rtl/rmst_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rmst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rmst_arbiter
//  Purpose  : Round-robin sharing of one AXI read-master channel among
//             NUM_REQ buffers. Latches request pulses, issues one burst at a
//             time, steers the returned stream to the granted buffer and
//             reports per-requester completion once the burst has landed.
//  Revision : 1.0  initial release
// ============================================================================
module rmst_arbiter #(
   parameter int DATA_WIDTH = 512,
   parameter int NUM_REQ    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_pulse,
   input  logic [NUM_REQ*64-1:0]      req_addr,
   input  logic [NUM_REQ*64-1:0]      req_size,
   input  logic [NUM_REQ-1:0]         req_clear,
   output logic [NUM_REQ-1:0]         req_done,
   output logic                       m_start,
   output logic [63:0]                m_addr,
   output logic [63:0]                m_size,
   input  logic                       m_done,
   input  logic [DATA_WIDTH-1:0]      s_tdata,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   output logic [DATA_WIDTH-1:0]      o_tdata,
   output logic [NUM_REQ-1:0]         o_tvalid,
   input  logic [NUM_REQ-1:0]         o_tready,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int DATA_WIDTH_BYTE = DATA_WIDTH / 8;
   localparam int BEAT_SHIFT      = $clog2(DATA_WIDTH_BYTE);
   localparam int ID_W            = $clog2(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [NUM_REQ-1:0] pend;
   logic [ID_W-1:0]    last_grant;
   logic [63:0]        beat_cnt;
   logic               done_seen;
   logic [63:0]        beat_target;
   logic               beat;
   logic               pick_valid;
   logic [ID_W-1:0]    pick_id;
   logic [ID_W-1:0]    cand;
   logic               grant_now;
   logic [NUM_REQ-1:0] pick_oh;
   logic [NUM_REQ-1:0] inflight_oh;

   // Beats needed for the burst: ceil(m_size / bytes-per-beat), overflow-free on 64 bits.
   assign beat_target = (m_size >> BEAT_SHIFT) + {63'd0, |m_size[BEAT_SHIFT-1:0]};

   // Round-robin pick: first pending requester after the last grant, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = last_grant;
      cand       = last_grant;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (cand == LAST_ID) ? '0 : cand + ID_W'(1);
         if (!pick_valid && pend[cand]) begin
            pick_valid = 1'b1;
            pick_id    = cand;
         end
      end
   end

   assign grant_now   = (state == IDLE) && pick_valid;
   assign pick_oh     = grant_now ? (NUM_REQ'(1) << pick_id) : '0;
   // A pulse from the requester currently being served is absorbed.
   assign inflight_oh = (state != IDLE) ? (NUM_REQ'(1) << grant_id) : '0;

   // Pending flags: a pulse beats a clear; a grant consumes the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else begin
         pend <= (req_pulse & ~inflight_oh & ~pick_oh) | (pend & ~req_clear & ~pick_oh);
      end
   end

   // Grant bookkeeping and burst parameters, updated only on IDLE->ISSUE.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id   <= '0;
         last_grant <= LAST_ID;
         m_addr     <= '0;
         m_size     <= '0;
      end else if (grant_now) begin
         grant_id   <= pick_id;
         last_grant <= pick_id;
         m_addr     <= req_addr[{pick_id, 6'd0} +: 64];
         m_size     <= req_size[{pick_id, 6'd0} +: 64];
      end
   end

   // Beat counter and sticky read-master completion flag.
   always_ff @(posedge clk) begin
      if (rst || state == DONE) begin
         beat_cnt  <= '0;
         done_seen <= 1'b0;
      end else if (state == XFER) begin
         if (beat) begin
            beat_cnt <= beat_cnt + 64'd1;
         end
         if (m_done) begin
            done_seen <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus combinational stream routing and strobes.
   always_comb begin
      state_nxt = state;
      m_start   = 1'b0;
      req_done  = '0;
      s_tready  = 1'b0;
      o_tvalid  = '0;
      o_tdata   = s_tdata;
      busy      = (state != IDLE);

      if (state == XFER) begin
         s_tready = o_tready[grant_id];
         if (s_tvalid) begin
            o_tvalid = NUM_REQ'(1) << grant_id;
         end
      end
      beat = s_tvalid & s_tready;

      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (m_size != 64'd0) begin
               m_start   = 1'b1;
               state_nxt = XFER;
            end else begin
               state_nxt = DONE;
            end
         end
         XFER: begin
            // m_done and the final beat may land in either order or together.
            if ((done_seen || m_done) &&
                ((beat_cnt + {63'd0, beat}) >= beat_target)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            req_done  = NUM_REQ'(1) << grant_id;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire
